// File: rtl/peak_sched_pkg.sv
// -----------------------------------------------------------------------------
// peak_sched_pkg
// Shared definitions for the peak-data output scheduler.
//   sched_state_t : scheduler FSM states (IDLE, XFER, CLOSE)
//   SCHED_ERR_TAG : all-ones tag pattern stamped on a watchdog-closed beat
//   TOCNT_W       : width of the forced-close counter
// -----------------------------------------------------------------------------
package peak_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_CLOSE = 2'd2
  } sched_state_t;

  // Wide enough for any supported tag mask; users slice the low NUM_TAGS bits.
  localparam logic [63:0] SCHED_ERR_TAG = '1;

  localparam int TOCNT_W = 16;

endpackage

// File: rtl/peak_data_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin first-set finder. Scans i_req starting at index
// i_ptr and wrapping, and reports the first set position.
// Ports:
//   i_req   [N-1:0]   request vector
//   i_ptr   [IW-1:0]  scan start index (0..N-1)
//   o_found           any request set
//   o_idx   [IW-1:0]  first set index at or after i_ptr (modulo N)
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx
);

  int          w_k;
  logic [IW-1:0] w_kk;

  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_k     = 0;
    w_kk    = '0;
    for (int i = 0; i < N; i++) begin
      // i_ptr is always < N, so one conditional subtract gives the wrap.
      w_k = int'(i_ptr) + i;
      if (w_k >= N) w_k = w_k - N;
      w_kk = IW'(w_k);
      if (!o_found && i_req[w_kk]) begin
        o_found = 1'b1;
        o_idx   = w_kk;
      end
    end
  end

endmodule

// File: rtl/peak_data_sched.sv
// -----------------------------------------------------------------------------
// peak_data_sched
// Round-robin packet scheduler sharing the single AXI-stream write port of the
// peak-data output buffer among NUM_SOURCES detector streams. A source owns
// the port from its first beat through tlast, so a packet is never split and
// its tag mask stays with its data.
//
// Optional feature macro: PEAK_SCHED_TIMEOUT_EN
//   defined   : watchdog closes a packet whose owner stalls for TIMEOUT
//               cycles, emitting an error beat (tdata=0, tuser all ones,
//               tlast=1) and counting it in timeout_count.
//   undefined : a stalled owner holds the grant forever; timeout_count = 0.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_axis_tvalid/tready per-source handshake [NUM_SOURCES]
//   s_axis_tdata         source n at [n*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tuser         source n at [n*NUM_TAGS +: NUM_TAGS]
//   s_axis_tlast         per-source end of packet
//   m_axis_*             merged stream toward the buffer
//   grant_id             current or most recent owner
//   busy                 high while a packet (or forced close) is in flight
//   timeout_count        saturating count of forced closes
// -----------------------------------------------------------------------------
module peak_data_sched
  import peak_sched_pkg::*;
#(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 128,
  parameter int NUM_TAGS    = 10,
  parameter int TIMEOUT     = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SOURCES-1:0]           s_axis_tvalid,
  output logic [NUM_SOURCES-1:0]           s_axis_tready,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SOURCES*NUM_TAGS-1:0]  s_axis_tuser,
  input  logic [NUM_SOURCES-1:0]           s_axis_tlast,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [NUM_TAGS-1:0]              m_axis_tuser,
  output logic                             m_axis_tlast,
  output logic [$clog2(NUM_SOURCES)-1:0]   grant_id,
  output logic                             busy,
  output logic [TOCNT_W-1:0]               timeout_count
);

  localparam int IDX_W = $clog2(NUM_SOURCES);

  // Elaboration-time parameter sanity check.
  if (NUM_SOURCES < 2 || NUM_SOURCES > 8 || NUM_TAGS > 64 || TIMEOUT < 2) begin : g_param_check
    $error("peak_data_sched: unsupported parameter set");
  end

  function automatic logic [IDX_W-1:0] f_next_ptr(input logic [IDX_W-1:0] cur);
    if (cur == IDX_W'(NUM_SOURCES - 1)) return '0;
    else                                return cur + 1'b1;
  endfunction

  sched_state_t     r_state;
  logic [IDX_W-1:0] r_grant_id;
  logic [IDX_W-1:0] r_rr_ptr;

  logic             w_found;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_src_valid;
  logic             w_src_last;
  logic             w_src_hs;

  rr_pick #(
    .N  (NUM_SOURCES),
    .IW (IDX_W)
  ) u_rr_pick (
    .i_req   (s_axis_tvalid),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_pick_idx)
  );

  assign w_src_valid = s_axis_tvalid[r_grant_id];
  assign w_src_last  = s_axis_tlast[r_grant_id];
  assign w_src_hs    = w_src_valid && m_axis_tready;

  assign grant_id = r_grant_id;
  assign busy     = (r_state != ST_IDLE);

`ifdef PEAK_SCHED_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT);

  function automatic logic [TOCNT_W-1:0] f_sat_inc(input logic [TOCNT_W-1:0] c);
    if (c == '1) return c;
    else         return c + 1'b1;
  endfunction

  logic [STALL_W-1:0] r_stall_cnt;
  logic [TOCNT_W-1:0] r_timeout_count;

  assign timeout_count = r_timeout_count;
`else
  assign timeout_count = '0;
`endif

  // Scheduler FSM: grant selection, packet ownership, watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_grant_id      <= '0;
      r_rr_ptr        <= '0;
`ifdef PEAK_SCHED_TIMEOUT_EN
      r_stall_cnt     <= '0;
      r_timeout_count <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_grant_id <= w_pick_idx;
            r_state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (w_src_hs) begin
`ifdef PEAK_SCHED_TIMEOUT_EN
            r_stall_cnt <= '0;
`endif
            if (w_src_last) begin
              r_rr_ptr <= f_next_ptr(r_grant_id);
              r_state  <= ST_IDLE;
            end
          end
`ifdef PEAK_SCHED_TIMEOUT_EN
          // Backpressure with valid data is not a stall; only a silent
          // owner advances the counter.
          else if (r_stall_cnt == STALL_W'(TIMEOUT - 1)) begin
            r_stall_cnt <= '0;
            r_state     <= ST_CLOSE;
          end else if (!w_src_valid) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
          end
`endif
        end
`ifdef PEAK_SCHED_TIMEOUT_EN
        ST_CLOSE: begin
          if (m_axis_tready) begin
            r_timeout_count <= f_sat_inc(r_timeout_count);
            r_rr_ptr        <= f_next_ptr(r_grant_id);
            r_state         <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output mux: purely combinational from registered state and grant.
  always_comb begin
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tuser  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      ST_XFER: begin
        m_axis_tvalid             = w_src_valid;
        m_axis_tdata              = s_axis_tdata[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tuser              = s_axis_tuser[int'(r_grant_id)*NUM_TAGS +: NUM_TAGS];
        m_axis_tlast              = w_src_last;
        s_axis_tready[r_grant_id] = m_axis_tready;
      end
`ifdef PEAK_SCHED_TIMEOUT_EN
      ST_CLOSE: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = 1'b1;
        m_axis_tuser  = SCHED_ERR_TAG[NUM_TAGS-1:0];
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: doc/peak_data_sched.md
# peak_data_sched

Round-robin packet scheduler that shares the single AXI-stream write port of the peak-data output buffer among several peak-detector sources. It grants one source at a time for a whole packet, from first beat through `tlast`, and forwards that source's data, tag mask and `tlast` unchanged. A grant is therefore never split mid-packet, and the buffer's per-packet tag word always stays attached to its own data. An optional watchdog closes a packet whose source stalls mid-packet.

## Interface
Parameters:
- `NUM_SOURCES`, 4: number of requesting detector streams (2..8).
- `DATA_WIDTH`, 128: beat width; matches buffer `NUM_CHANNELS*CHANNEL_WIDTH`.
- `NUM_TAGS`, 10: width of `tuser` tag mask.
- `TIMEOUT`, 256: stall cycles before a forced close (watchdog builds only).

Ports:
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `s_axis_tvalid`  in  NUM_SOURCES  per-source valid.
- `s_axis_tready`  out  NUM_SOURCES  per-source ready.
- `s_axis_tdata`  in  NUM_SOURCES*DATA_WIDTH  source n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tuser`  in  NUM_SOURCES*NUM_TAGS  per-source tag mask, packed the same way.
- `s_axis_tlast`  in  NUM_SOURCES  per-source end of packet.
- `m_axis_tvalid`  out  1  to buffer.
- `m_axis_tready`  in  1  from buffer.
- `m_axis_tdata`  out  DATA_WIDTH  to buffer.
- `m_axis_tuser`  out  NUM_TAGS  to buffer.
- `m_axis_tlast`  out  1  to buffer.
- `grant_id`  out  clog2(NUM_SOURCES)  index of the current or most recent owner.
- `busy`  out  1  high in XFER and CLOSE.
- `timeout_count`  out  16  saturating count of forced closes.

## Operation
- Registered state: `state`, `grant_id`, `rr_ptr`, `stall_cnt`, `timeout_count`.
- States:
  - IDLE: scan requests `s_axis_tvalid`, starting at `rr_ptr`. If any request is set, register the first set index into `grant_id` and go to XFER. Otherwise stay in IDLE.
  - XFER: mux source `grant_id` to `m_axis_*`.
    - `m_axis_tvalid = s_axis_tvalid[grant_id]`.
    - `s_axis_tready[grant_id] = m_axis_tready`; all other `tready` bits are 0.
    - On a beat handshake with `tlast` high: set `rr_ptr = grant_id+1`, wrapping modulo `NUM_SOURCES`, and go to IDLE.
  - CLOSE (watchdog builds only): drive `m_axis_tvalid=1`, `tlast=1`, `tdata=0`, `tuser` all ones (error marker). All `s_axis_tready` bits are 0. On `m_axis_tready`, increment `timeout_count`, advance `rr_ptr` as in XFER, and go to IDLE.
- Output mux is combinational from registered `grant_id`/`state`; no data registers in the path.
- In IDLE all `s_axis_tready` are 0 and `m_axis_tvalid` = 0.
- A request that is raised and then dropped while in IDLE is simply re-scanned each cycle; there is no sticky request.
- Single-beat packets (`tlast` on the first beat) are legal.
- Backpressure from `m_axis_tready` low holds the granted source; it is not a stall.
- Sources not granted see `tready` 0 indefinitely; they are never dropped.

## Timing
- Reset values:
  - `state`=IDLE, `grant_id`=0, `rr_ptr`=0, `stall_cnt`=0, `timeout_count`=0.
  - `m_axis_tvalid`=0, all `s_axis_tready`=0, `busy`=0.
  - `m_axis_tdata`, `m_axis_tuser` and `m_axis_tlast` are 0 while in IDLE.
- Request to first forwarded beat: 1 cycle (IDLE decides, XFER forwards the following cycle).
- Packet boundary: exactly 1 idle bubble between back-to-back packets, even from the same source.
- Fairness: with all sources continuously requesting, grants go 0,1,2,3,0,... with 1-beat packets; each source is served within at most NUM_SOURCES packets.
- `stall_cnt`:
  - Clears on every granted handshake and on leaving XFER.
  - Increments in XFER when `s_axis_tvalid[grant_id]`=0.
  - Does not increment while the source is valid but `m_axis_tready`=0.
  - Reaching `TIMEOUT-1` moves XFER to CLOSE on the next edge.
- `timeout_count` saturates at 16'hFFFF.
- Reset asserted mid-packet returns immediately to IDLE. The buffer may then hold a partial packet without a tag word; upstream reset is required alongside.

## Configuration
- `PEAK_SCHED_TIMEOUT_EN` defined: watchdog, CLOSE state and `stall_cnt` are present; `timeout_count` counts forced closes.
- `PEAK_SCHED_TIMEOUT_EN` undefined:
  - No CLOSE state and no `stall_cnt`.
  - A stalled owner holds the grant forever.
  - `timeout_count` is tied to 0.

## Structure
- Shared package `peak_sched_pkg`:
  - State enum (IDLE, XFER, CLOSE).
  - `SCHED_ERR_TAG` all-ones marker constant.
  - Counter width `TOCNT_W`=16.
- One sub-module, `rr_pick`: combinational round-robin first-set finder. Inputs: request vector and pointer. Outputs: found flag and index.

## Test plan
- Single source 0, 3-beat packet, `tuser`=10'h005, `m_axis_tready`=1 → beats appear on `m_axis` at cycles 1-3, `tlast` on beat 3, `tuser`=10'h005 on all beats, `grant_id`=0.
- All four sources continuously valid with 1-beat packets → output order 0,1,2,3,0 with one bubble between each packet.
- Source 2 granted, `m_axis_tready` low for 50 cycles mid-packet → no data loss, no timeout, `s_axis_tready[2]` mirrors `m_axis_tready`.
- Watchdog build, `TIMEOUT`=8, source 1 drops `tvalid` after beat 1 → CLOSE beat with `tdata`=0, `tuser`=10'h3FF, `tlast`=1; `timeout_count`=1; next grant goes to source 2.
- `rst_n` pulsed low while in XFER → all outputs at reset values within the same cycle; after release, grant restarts from `rr_ptr`=0.
- Source 3 requests while source 0 has a 20-beat packet in progress → source 3's `tready` stays 0 until source 0's `tlast`; source 3 is then granted after one bubble.
